// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   inputP,
   input  logic [WIDTH-1:0]   inputQ,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done,
   output logic               zeroOperand
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] r_product;
   logic               r_zero;

   logic               w_accept;
   logic               w_zero_in;
   logic               w_last;
   logic [WIDTH-1:0]   w_mag_p;
   logic [WIDTH-1:0]   w_mag_q;
   logic [2*WIDTH-1:0] w_acc_sum;
   logic [2*WIDTH-1:0] w_result;

`ifdef MULT_SIGNED_EN
   logic               r_sign;

   // Magnitude of the most negative value still fits when read as unsigned.
   assign w_mag_p  = inputP[WIDTH-1] ? -inputP : inputP;
   assign w_mag_q  = inputQ[WIDTH-1] ? -inputQ : inputQ;
   assign w_result = r_sign ? -w_acc_sum : w_acc_sum;
`else
   assign w_mag_p  = inputP;
   assign w_mag_q  = inputQ;
   assign w_result = w_acc_sum;
`endif

   assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_zero_in = (inputP == '0) || (inputQ == '0);
   assign w_last    = (r_count == CW'(WIDTH - 1));
   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others regardless of process order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = w_zero_in ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_next = w_zero_in ? S_DONE : S_CALC;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_CALC:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_count   <= '0;
         r_product <= '0;
         r_zero    <= 1'b0;
`ifdef MULT_SIGNED_EN
         r_sign    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_acc    <= '0;
         r_count  <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, w_mag_p};
         r_mplier <= w_mag_q;
         r_zero   <= w_zero_in;
`ifdef MULT_SIGNED_EN
         r_sign   <= inputP[WIDTH-1] ^ inputQ[WIDTH-1];
`endif
         if (w_zero_in) begin
            r_product <= '0;
         end
      end else if (r_state == S_CALC) begin
         r_acc    <= w_acc_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + CW'(1);
         // Final iteration's partial sum goes straight to the product register.
         if (w_last) begin
            r_product <= w_result;
         end
      end
   end

   assign product     = r_product;
   assign zeroOperand = r_zero;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier with a done-triggered scoreboard monitor.
module tb_seq_multiplier;

   localparam int WIDTH = 16;
   localparam int LAT   = WIDTH + 1;

`ifdef MULT_SIGNED_EN
   localparam logic [31:0] E_FFFF_FFFF = 32'h0000_0001;
   localparam logic [31:0] E_FFFF_0002 = 32'hFFFF_FFFE;
   localparam logic [31:0] E_FFFD_0007 = 32'hFFFF_FFEB;
`else
   localparam logic [31:0] E_FFFF_FFFF = 32'hFFFE_0001;
   localparam logic [31:0] E_FFFF_0002 = 32'h0001_FFFE;
   localparam logic [31:0] E_FFFD_0007 = 32'h0006_FFEB;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] inputP;
   logic [15:0] inputQ;
   logic [31:0] product;
   logic        busy;
   logic        done;
   logic        zeroOperand;

   typedef struct {
      int unsigned cyc;
      logic [31:0] prod;
      logic        zero;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   seq_multiplier #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .inputP      (inputP),
      .inputQ      (inputQ),
      .product     (product),
      .busy        (busy),
      .done        (done),
      .zeroOperand (zeroOperand)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done at cycle %0d: got done=1, expected no pending result", cyc);
         end else begin
            e = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("product", product, e.prod);
            check("zeroOperand", 32'(zeroOperand), 32'(e.zero));
         end
      end
   end

   // Called just after a negedge; returns at the negedge of cycle 1.
   task automatic issue(input logic [15:0] p, input logic [15:0] q,
                        input logic [31:0] exp_prod, input bit track);
      exp_t e;
      start  = 1'b1;
      inputP = p;
      inputQ = q;
      if (track) begin
         e.zero = (p == 16'd0) || (q == 16'd0);
         e.cyc  = cyc + (e.zero ? 1 : LAT);
         e.prod = exp_prod;
         sb.push_back(e);
      end
      @(negedge clk);
      start  = 1'b0;
      inputP = 16'($urandom);
      inputQ = 16'($urandom);
   endtask

   // From cycle 1 through cycle WIDTH: busy high, product unchanged; ends at the done cycle.
   task automatic calc_window(input logic [31:0] hold);
      for (int k = 1; k <= WIDTH; k++) begin
         check("busy_calc", 32'(busy), 32'd1);
         check("product_hold", product, hold);
         @(negedge clk);
      end
      check("busy_at_done", 32'(busy), 32'd0);
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      inputP = '0;
      inputQ = '0;
      repeat (2) @(negedge clk);
      check("reset_product", product, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_zero", 32'(zeroOperand), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      issue(16'd3, 16'd5, 32'h0000_000F, 1'b1);
      calc_window(32'd0);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      issue(16'hFFFF, 16'hFFFF, E_FFFF_FFFF, 1'b1);
      calc_window(32'h0000_000F);
      @(negedge clk);
      issue(16'hFFFF, 16'h0002, E_FFFF_0002, 1'b1);
      calc_window(E_FFFF_FFFF);
      @(negedge clk);
      issue(16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
      calc_window(E_FFFF_0002);
      @(negedge clk);
      issue(16'hFFFD, 16'h0007, E_FFFD_0007, 1'b1);
      calc_window(32'h4000_0000);
      @(negedge clk);

      // Zero operand: straight to DONE, busy never rises.
      issue(16'h1234, 16'h0000, 32'd0, 1'b1);
      check("zero_busy_c1", 32'(busy), 32'd0);
      @(negedge clk);
      check("zero_busy_c2", 32'(busy), 32'd0);
      check("zero_flag_held", 32'(zeroOperand), 32'd1);
      check("zero_product_held", product, 32'd0);
      issue(16'h0000, 16'h0005, 32'd0, 1'b1);
      check("zero2_busy", 32'(busy), 32'd0);
      @(negedge clk);

      // start during CALC is ignored; back-to-back start in DONE is accepted.
      issue(16'd7, 16'd9, 32'd63, 1'b1);
      repeat (4) @(negedge clk);
      start  = 1'b1;
      inputP = 16'd2;
      inputQ = 16'd2;
      @(negedge clk);
      start = 1'b0;
      check("ignored_start_busy", 32'(busy), 32'd1);
      repeat (11) @(negedge clk);
      check("b2b_done_cycle_busy", 32'(busy), 32'd0);
      issue(16'd2, 16'd2, 32'd4, 1'b1);
      check("b2b_busy", 32'(busy), 32'd1);
      repeat (16) @(negedge clk);
      @(negedge clk);

      // Reset mid-CALC aborts with no done pulse.
      issue(16'd100, 16'd100, 32'd0, 1'b0);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_product", product, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_zero", 32'(zeroOperand), 32'd0);
      repeat (12) @(negedge clk);
      issue(16'd4, 16'd4, 32'd16, 1'b1);
      calc_window(32'd0);
      @(negedge clk);

      // Reset and start on the same edge: request dropped.
      reset  = 1'b1;
      start  = 1'b1;
      inputP = 16'd5;
      inputQ = 16'd5;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      check("rst_start_product", product, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_start_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-add multiplier for the calculator datapath, the inverse operation of the divider. It multiplies two 16-bit operands with a start/busy/done handshake and produces a 32-bit product. It handles one multiplier bit per clock. The Python middleware-facing control logic selects it for the multiply opcode.

## Interface
- `WIDTH`, default 16: operand width. The product is `2*WIDTH` bits wide.

- `clk`, input, 1 bit: the single clock. All logic is rising-edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `start`, input, 1 bit: request a multiply. Sampled only in IDLE or DONE.
- `inputP`, input, WIDTH bits: multiplicand. Latched on an accepted `start`.
- `inputQ`, input, WIDTH bits: multiplier. Latched on an accepted `start`.
- `product`, output, 2*WIDTH bits: result register. Holds its value until the next accepted `start` or `reset`.
- `busy`, output, 1 bit: high while in CALC.
- `done`, output, 1 bit: one-cycle pulse when `product` becomes valid.
- `zeroOperand`, output, 1 bit: high with `done` when either latched operand was 0. Held until the next accepted `start`.

## Operation
- States are IDLE, CALC and DONE. Encoding is free.
- IDLE:
  - `start=1` latches the operands and clears the accumulator and bit counter.
  - If either operand is 0, go to DONE with `product=0` and `zeroOperand=1`.
  - Otherwise go to CALC.
- CALC: on each edge:
  - If multiplier LSB is 1, `acc += mcand`.
  - Shift `mcand` left by 1 and the multiplier right by 1.
  - Increment the counter.
  - After WIDTH iterations, load `product` from `acc` and go to DONE.
- DONE:
  - `done=1` for exactly this cycle.
  - Next state is IDLE, unless `start=1`, which is accepted exactly as in IDLE (back-to-back operation).
- `start` during CALC is ignored. The operation in progress is unaffected and no request is queued.
- Arithmetic rules:
  - The accumulator and shifted multiplicand are 2*WIDTH bits.
  - No overflow is possible.
  - No carry-out is kept.
- Operand inputs may change freely after the accepting edge.
- Reset values: `product=0`, `busy=0`, `done=0`, `zeroOperand=0`, state IDLE, counter 0.

## Timing
- Cycle 0 is the cycle in which `start` is high and accepted.
- Nonzero operands:
  - `busy` is high in cycles 1..WIDTH (1..16 at the default width).
  - `done=1` and `product` are valid in cycle WIDTH+1 (cycle 17).
- Zero operand: `busy` stays 0. `done=1`, `product=0` and `zeroOperand=1` in cycle 1.
- A back-to-back `start` in the DONE cycle gives `busy` high in the following cycle. No IDLE cycle is inserted.
- Reset mid-CALC takes effect at the next edge:
  - All outputs return to their reset values.
  - No `done` pulse is produced for the aborted operation.
- Reset and `start` high on the same edge: reset wins and the request is dropped.
- `product` changes only at the edge that enters DONE, or on reset. It is never visible partially accumulated.

## Configuration
- `MULT_SIGNED_EN` defined:
  - Operands are two's complement.
  - On accept, the magnitudes of `inputP` and `inputQ` are latched, plus a result sign equal to the XOR of the operand MSBs.
  - The unsigned shift-add runs on the magnitudes.
  - On entry to DONE, `product` is the two's-complement negation of `acc` when the sign bit is set.
  - Latency is unchanged.
- `MULT_SIGNED_EN` undefined: operands are unsigned and no sign logic is present.

## Test plan
- `inputP=3`, `inputQ=5` -> `busy` in cycles 1-16, then `done` with `product=0x0000000F` in cycle 17, `zeroOperand=0`.
- Unsigned build, `0xFFFF*0xFFFF` -> `product=0xFFFE0001`. Signed build, same operands (-1*-1) -> `product=0x00000001`.
- Signed build, `0xFFFF*0x0002` -> `product=0xFFFFFFFE`, and `0x8000*0x8000` -> `product=0x40000000`.
- `inputP=0x1234`, `inputQ=0` -> `done` in cycle 1 with `product=0` and `zeroOperand=1`. `busy` is never asserted.
- Start `7*9`, pulse `start` with `2*2` in cycle 5 -> ignored, `product=63` in cycle 17. Then a new `start` in the DONE cycle with `2*2` -> `product=4` in cycle 34.
- Start `100*100`, assert `reset` in cycle 8 -> all outputs are 0 from cycle 9, with no `done` pulse. A subsequent `start` with `4*4` -> `product=16` 17 cycles later.
